// File: rtl/nibble_add_pkg.sv
// nibble_add_pkg: shared nibble width, beat-count helpers and controller state encoding
package nibble_add_pkg;
  localparam int NIB_W = 4;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  function automatic int nbeats(int w);
    return w / NIB_W;
  endfunction
  function automatic int beat_w(int w);
    return (w / NIB_W > 1) ? $clog2(w / NIB_W) : 1;
  endfunction
endpackage

// File: rtl/ripple_adder_4bit.sv
// ripple_adder_4bit: 4-bit ripple-carry adder slice shared by the serial add controller
module ripple_adder_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);
  logic c;
  always_comb begin
    sum = '0;
    c = cin;
    for (int i = 0; i < 4; i++) begin
      sum[i] = a[i] ^ b[i] ^ c;
      c = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    cout = c;
  end
endmodule

// File: rtl/nibble_serial_add_ctrl.sv
// nibble_serial_add_ctrl: round-robin multi-requester W-bit adder sequenced over one 4-bit slice
// Define NIBBLE_ADD_APX_LSB_SKIP_EN to skip the low APX_NIBBLES nibbles (result bits forced to 0).
module nibble_serial_add_ctrl
  import nibble_add_pkg::*;
#(
  parameter int W           = 32,
  parameter int NREQ        = 2,
  parameter int APX_NIBBLES = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ*W-1:0]       req_a,
  input  logic [NREQ*W-1:0]       req_b,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [W-1:0]            rsp_sum,
  output logic                    rsp_cout,
  output logic [$clog2(NREQ)-1:0] rsp_id,
  output logic                    busy
);
  localparam int NB  = nbeats(W);
  localparam int BW  = beat_w(W);
  localparam int IDW = $clog2(NREQ);
`ifdef NIBBLE_ADD_APX_LSB_SKIP_EN
  localparam bit APX_EN = 1'b1;
`else
  localparam bit APX_EN = 1'b0;
`endif
  localparam logic [BW-1:0] FIRST = BW'(APX_EN ? APX_NIBBLES : 0);
  localparam logic [BW-1:0] LAST  = BW'(NB - 1);
  state_t state, state_d;
  logic [W-1:0]     a_r, b_r, res_r;
  logic             carry_r;
  logic [BW-1:0]    beat_r;
  logic [IDW-1:0]   id_r, rr_ptr, win, idx;
  logic             found, accept;
  logic [NIB_W-1:0] nib_sum;
  logic             nib_cout;
  // first valid requester at or above the pointer, wrapping
  always_comb begin
    found = 1'b0;
    win = '0;
    idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = IDW'((int'(rr_ptr) + k) % NREQ);
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        win = idx;
      end
    end
  end
  always_comb begin
    state_d = state == IDLE ? (found ? RUN : IDLE) :
              state == RUN  ? (beat_r == LAST ? DONE : RUN) :
              state == DONE ? (rsp_ready ? IDLE : DONE) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else state <= state_d;
  end
  assign accept    = state == IDLE && found;
  assign req_ready = accept ? {{(NREQ-1){1'b0}}, 1'b1} << win : '0;
  assign rsp_valid = state == DONE;
  assign busy      = state != IDLE;
  assign rsp_sum   = res_r;
  assign rsp_cout  = carry_r;
  assign rsp_id    = id_r;
  ripple_adder_4bit u_add (
    .a    (a_r[beat_r*NIB_W +: NIB_W]),
    .b    (b_r[beat_r*NIB_W +: NIB_W]),
    .cin  (carry_r),
    .sum  (nib_sum),
    .cout (nib_cout)
  );
  // result is cleared on accept so skipped low nibbles read as zero
  always_ff @(posedge clk) begin
    if (!rst) begin
      a_r <= '0;
      b_r <= '0;
      res_r <= '0;
      carry_r <= 1'b0;
      beat_r <= '0;
      id_r <= '0;
      rr_ptr <= '0;
    end else if (accept) begin
      a_r <= req_a[win*W +: W];
      b_r <= req_b[win*W +: W];
      res_r <= '0;
      carry_r <= 1'b0;
      beat_r <= FIRST;
      id_r <= win;
      rr_ptr <= win == IDW'(NREQ - 1) ? '0 : win + 1'b1;
    end else if (state == RUN) begin
      res_r[beat_r*NIB_W +: NIB_W] <= nib_sum;
      carry_r <= nib_cout;
      beat_r <= beat_r + 1'b1;
    end
  end
endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// tb_nibble_serial_add_ctrl: directed self-checking bench for nibble_serial_add_ctrl
module tb_nibble_serial_add_ctrl;
  localparam int W = 32;
  localparam int NREQ = 2;
`ifdef NIBBLE_ADD_APX_LSB_SKIP_EN
  `define SEL(x, y) (y)
  localparam int LAT = 7;
`else
  `define SEL(x, y) (x)
  localparam int LAT = 9;
`endif
  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [NREQ-1:0] req_valid = '0;
  logic [NREQ-1:0] req_ready;
  logic [NREQ*W-1:0] req_a = '0;
  logic [NREQ*W-1:0] req_b = '0;
  logic            rsp_valid;
  logic            rsp_ready = 1'b0;
  logic [W-1:0]    rsp_sum;
  logic            rsp_cout;
  logic [0:0]      rsp_id;
  logic            busy;
  int n_chk = 0;
  int n_fail = 0;

  nibble_serial_add_ctrl #(.W(W), .NREQ(NREQ), .APX_NIBBLES(2)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_sum(rsp_sum), .rsp_cout(rsp_cout), .rsp_id(rsp_id), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int id, input logic [31:0] a, input logic [31:0] b);
    req_a[id*W +: W] = a;
    req_b[id*W +: W] = b;
    req_valid[id] = 1'b1;
  endtask

  task automatic grant(input int id, input bit keep);
    #1;
    check("req_ready_grant", req_ready, 64'(1) << id);
    step();
    if (!keep) req_valid[id] = 1'b0;
    check("req_ready_run", req_ready, 0);
    check("busy_run", busy, 1);
  endtask

  task automatic wait_rsp(input int id, input logic [31:0] es, input logic ec, input int hold);
    int lat = 1;
    while (!rsp_valid && lat < 30) begin
      step();
      lat++;
    end
    check("latency", lat, LAT);
    check("rsp_sum", rsp_sum, es);
    check("rsp_cout", rsp_cout, ec);
    check("rsp_id", rsp_id, id);
    repeat (hold) begin
      step();
      check("hold_valid", rsp_valid, 1);
      check("hold_sum", rsp_sum, es);
      check("hold_id", rsp_id, id);
      check("hold_req_ready", req_ready, 0);
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    check("rsp_valid_drop", rsp_valid, 0);
  endtask

  initial begin
    int seen;
    step();
    step();
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_req_ready", req_ready, 0);
    check("rst_rsp_sum", rsp_sum, 0);
    check("rst_rsp_cout", rsp_cout, 0);
    check("rst_rsp_id", rsp_id, 0);
    rst = 1'b1;
    step();
    // both requesters held valid: service alternates 0,1,0,1
    set_req(0, 32'h11000011, 32'h22000022);
    set_req(1, 32'h01010101, 32'h10101010);
    grant(0, 1);
    wait_rsp(0, `SEL(32'h33000033, 32'h33000000), 1'b0, 0);
    grant(1, 1);
    wait_rsp(1, `SEL(32'h11111111, 32'h11111100), 1'b0, 0);
    grant(0, 1);
    wait_rsp(0, `SEL(32'h33000033, 32'h33000000), 1'b0, 0);
    grant(1, 0);
    req_valid = '0;
    wait_rsp(1, `SEL(32'h11111111, 32'h11111100), 1'b0, 0);
    set_req(0, 32'hFFFFFFFF, 32'h00000001);
    grant(0, 0);
    wait_rsp(0, `SEL(32'h00000000, 32'hFFFFFF00), `SEL(1'b1, 1'b0), 0);
    set_req(1, 32'h0FFFFFFF, 32'h00000001);
    grant(1, 0);
    wait_rsp(1, `SEL(32'h10000000, 32'h0FFFFF00), 1'b0, 0);
    set_req(0, 32'h12345678, 32'h11111111);
    grant(0, 0);
    wait_rsp(0, `SEL(32'h23456789, 32'h23456700), 1'b0, 0);
    set_req(1, 32'h80000000, 32'h80000000);
    grant(1, 0);
    wait_rsp(1, 32'h00000000, 1'b1, 0);
    set_req(0, 32'h89ABCDEF, 32'h76543210);
    grant(0, 0);
    wait_rsp(0, `SEL(32'hFFFFFFFF, 32'hFFFFFF00), 1'b0, 0);
    // backpressure: response held 5 cycles while req1 waits
    set_req(0, 32'h12345678, 32'h11111111);
    grant(0, 0);
    set_req(1, 32'h0FFFFFFF, 32'h00000001);
    wait_rsp(0, `SEL(32'h23456789, 32'h23456700), 1'b0, 5);
    grant(1, 0);
    wait_rsp(1, `SEL(32'h10000000, 32'h0FFFFF00), 1'b0, 0);
    // reset during RUN beat 4
    set_req(0, 32'hFFFFFFFF, 32'h00000001);
    grant(0, 0);
    repeat (4) step();
    check("midop_busy", busy, 1);
    rst = 1'b0;
    step();
    check("abort_rsp_valid", rsp_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_req_ready", req_ready, 0);
    check("abort_rsp_sum", rsp_sum, 0);
    check("abort_rsp_cout", rsp_cout, 0);
    rst = 1'b1;
    seen = 0;
    repeat (12) begin
      step();
      if (rsp_valid) seen++;
    end
    check("no_stale_rsp", seen, 0);
    set_req(0, 32'h11000011, 32'h22000022);
    set_req(1, 32'h01010101, 32'h10101010);
    grant(0, 0);
    wait_rsp(0, `SEL(32'h33000033, 32'h33000000), 1'b0, 0);
    grant(1, 0);
    wait_rsp(1, `SEL(32'h11111111, 32'h11111100), 1'b0, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
